// File: rtl/decode_stage_pkg.sv
// Shared constants, instruction field positions and immediate-extension helper
// for the decode stage and its register file.
package decode_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RD_HI  = 20;
  localparam int RD_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    IMM_SEXT     = 2'b00,
    IMM_ZEXT     = 2'b01,
    IMM_HI16     = 2'b10,
    IMM_SEXT_SL2 = 2'b11
  } immext_e;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm, input immext_e sel);
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] res;
    sext = {{(DATA_W-16){imm[15]}}, imm};
    case (sel)
      IMM_SEXT:     res = sext;
      IMM_ZEXT:     res = {{(DATA_W-16){1'b0}}, imm};
      IMM_HI16:     res = {imm, 16'h0000};
      IMM_SEXT_SL2: res = {sext[DATA_W-3:0], 2'b00};
      default:      res = sext;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Register file: two combinational read ports, one synchronous write port, r0 fixed at zero.
// DECODE_STAGE_RF_BYPASS_EN selects write-first reads; otherwise reads are read-first.
module decode_stage_regfile
  import decode_stage_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int DW    = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DW-1:0]     rdata_a,
  output logic [DW-1:0]     rdata_b,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DW-1:0]     wdata
);

  logic [DW-1:0] regs [NREGS];
  logic          wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

`ifdef DECODE_STAGE_RF_BYPASS_EN
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (raddr_a != '0) rdata_a = (wr_en && waddr == raddr_a) ? wdata : regs[raddr_a];
    if (raddr_b != '0) rdata_b = (wr_en && waddr == raddr_b) ? wdata : regs[raddr_b];
  end
`else
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (raddr_a != '0) rdata_a = regs[raddr_a];
    if (raddr_b != '0) rdata_b = regs[raddr_b];
  end
`endif

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: register-file reads, immediate extension and the
// operand pipeline register. Optional macro: DECODE_STAGE_RF_BYPASS_EN.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int DW    = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              rf_b_sel,
  input  logic [1:0]        immext_sel,
  input  logic              rf_we,
  input  logic [REG_AW-1:0] rf_waddr,
  input  logic              rf_wrdata_sel,
  input  logic [DW-1:0]     alu_out,
  input  logic [DW-1:0]     mem_out,
  output logic [DW-1:0]     rfa,
  output logic [DW-1:0]     rfb,
  output logic [DW-1:0]     immed,
  output logic              out_valid
);

  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] raddr_b;
  logic [DW-1:0]     rdata_a;
  logic [DW-1:0]     rdata_b;
  logic [DW-1:0]     wdata;
  logic [DW-1:0]     immed_d;
  logic              opc_unused;

  assign rs         = instr[RS_HI:RS_LO];
  assign rd         = instr[RD_HI:RD_LO];
  assign rt         = instr[RT_HI:RT_LO];
  assign raddr_b    = rf_b_sel ? rd : rt;
  assign wdata      = rf_wrdata_sel ? mem_out : alu_out;
  assign immed_d    = ext_imm(instr[IMM_HI:IMM_LO], immext_e'(immext_sel));
  // The opcode is decoded downstream; this stage only forwards operands.
  assign opc_unused = ^instr[OPC_HI:OPC_LO];

  decode_stage_regfile #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (wdata)
  );

  // Flush only drops the valid bit; stale data is harmless once invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rfa       <= '0;
      rfb       <= '0;
      immed     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      rfa       <= rdata_a;
      rfb       <= rdata_b;
      immed     <= immed_d;
      out_valid <= instr_valid;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed steps from the test plan followed
// by randomized traffic, all checked against a behavioural model of the stage.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        flush;
  logic        rf_b_sel;
  logic [1:0]  immext_sel;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        rf_wrdata_sel;
  logic [31:0] alu_out;
  logic [31:0] mem_out;
  logic [31:0] rfa;
  logic [31:0] rfb;
  logic [31:0] immed;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] mrf [32];
  logic [31:0] e_rfa, e_rfb, e_imm;
  logic        e_v;

  decode_stage dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .stall         (stall),
    .flush         (flush),
    .rf_b_sel      (rf_b_sel),
    .immext_sel    (immext_sel),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wrdata_sel (rf_wrdata_sel),
    .alu_out       (alu_out),
    .mem_out       (mem_out),
    .rfa           (rfa),
    .rfb           (rfb),
    .immed         (immed),
    .out_valid     (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input int rs, input int rd, input int low16);
    logic [31:0] v;
    v = (rs * 32'h0020_0000) + (rd * 32'h0001_0000) + (low16 % 65536);
    return v;
  endfunction

  function automatic logic [31:0] model_wdata();
    return rf_wrdata_sel ? mem_out : alu_out;
  endfunction

  function automatic logic [31:0] model_read(input int addr);
    if (addr == 0) return 32'h0;
`ifdef DECODE_STAGE_RF_BYPASS_EN
    if (rf_we && rf_waddr != 0 && int'(rf_waddr) == addr) return model_wdata();
`endif
    return mrf[addr];
  endfunction

  // Immediate rules evaluated as plain integer arithmetic (32-bit wrap).
  function automatic logic [31:0] model_imm(input int imm, input int sel);
    int s;
    s = (imm >= 32768) ? imm - 65536 : imm;
    case (sel)
      0:       return 32'(s);
      1:       return 32'(imm);
      2:       return 32'(imm * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  // One clock: predict the outputs after the edge, advance the model, compare.
  task automatic cycle(input string tag);
    int rs_i, rd_i, rt_i, imm_i;
    rs_i  = int'(instr / 32'h0020_0000) % 32;
    rd_i  = int'(instr / 32'h0001_0000) % 32;
    rt_i  = int'(instr / 32'h0000_0800) % 32;
    imm_i = int'(instr % 32'h0001_0000);
    if (rst) begin
      for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
      e_rfa = 0; e_rfb = 0; e_imm = 0; e_v = 1'b0;
    end else begin
      if (flush) begin
        e_v = 1'b0;
      end else if (!stall) begin
        e_rfa = model_read(rs_i);
        e_rfb = model_read(rf_b_sel ? rd_i : rt_i);
        e_imm = model_imm(imm_i, int'(immext_sel));
        e_v   = instr_valid;
      end
      if (rf_we && rf_waddr != 0) mrf[rf_waddr] = model_wdata();
    end
    @(posedge clk);
    #1;
    chk({tag, ".rfa"}, rfa, e_rfa);
    chk({tag, ".rfb"}, rfb, e_rfb);
    chk({tag, ".immed"}, immed, e_imm);
    chk({tag, ".valid"}, {31'h0, out_valid}, {31'h0, e_v});
  endtask

  task automatic idle_inputs();
    rst = 0; instr = 0; instr_valid = 0; stall = 0; flush = 0; rf_b_sel = 0;
    immext_sel = 0; rf_we = 0; rf_waddr = 0; rf_wrdata_sel = 0; alu_out = 0; mem_out = 0;
  endtask

  initial begin
    logic [31:0] frz_a, frz_b, frz_i;
    for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    e_rfa = 0; e_rfb = 0; e_imm = 0; e_v = 0;
    idle_inputs();

    // Reset
    rst = 1;
    cycle("reset");
    chk("reset.valid_const", {31'h0, out_valid}, 32'h0);
    rst = 0;

    // rs=3, rt=4 after reset reads zeros
    instr = mk_instr(3, 0, 4 * 2048); instr_valid = 1;
    cycle("rs3rt4");
    chk("rs3rt4.rfa_const", rfa, 32'h0);
    chk("rs3rt4.valid_const", {31'h0, out_valid}, 32'h1);

    // Write r5 via alu_out, then attempt r0 via mem_out, then decode
    instr_valid = 0;
    rf_we = 1; rf_waddr = 5; rf_wrdata_sel = 0; alu_out = 32'hDEADBEEF;
    cycle("wr_r5");
    rf_waddr = 0; rf_wrdata_sel = 1; mem_out = 32'h12345678;
    cycle("wr_r0");
    rf_we = 0;
    instr = mk_instr(5, 0, 0); instr_valid = 1; rf_b_sel = 1;
    cycle("rd_r5_r0");
    chk("rd_r5.const", rfa, 32'hDEADBEEF);
    chk("rd_r0.const", rfb, 32'h0);
    rf_b_sel = 0;

    // Immediate extension modes for 0x8001
    instr = mk_instr(0, 0, 16'h8001);
    immext_sel = 2'b00; cycle("imm_sext"); chk("imm_sext.const", immed, 32'hFFFF8001);
    immext_sel = 2'b01; cycle("imm_zext"); chk("imm_zext.const", immed, 32'h00008001);
    immext_sel = 2'b10; cycle("imm_hi16"); chk("imm_hi16.const", immed, 32'h80010000);
    immext_sel = 2'b11; cycle("imm_sl2");  chk("imm_sl2.const",  immed, 32'hFFFE0004);
    immext_sel = 2'b00;

    // Same-cycle write and read of r7
    rf_we = 1; rf_waddr = 7; rf_wrdata_sel = 0; alu_out = 32'h11; instr_valid = 0;
    cycle("r7_init");
    alu_out = 32'h22; instr = mk_instr(7, 0, 0); instr_valid = 1;
    cycle("r7_same");
`ifdef DECODE_STAGE_RF_BYPASS_EN
    chk("r7_same.const", rfa, 32'h22);
`else
    chk("r7_same.const", rfa, 32'h11);
`endif
    rf_we = 0;
    cycle("r7_next");
    chk("r7_next.const", rfa, 32'h22);

    // Stall for three cycles while instr changes, with a write to r5 meanwhile
    instr = mk_instr(5, 7, 16'h1234); rf_b_sel = 1;
    cycle("pre_stall");
    frz_a = rfa; frz_b = rfb; frz_i = immed;
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      instr = $urandom; instr_valid = k[0];
      rf_we = (k == 1); rf_waddr = 5; alu_out = 32'hCAFE0000;
      cycle("stall");
      chk("stall.frozen_a", rfa, frz_a);
      chk("stall.frozen_b", rfb, frz_b);
      chk("stall.frozen_i", immed, frz_i);
    end
    rf_we = 0;
    flush = 1;
    cycle("stall_flush");
    chk("stall_flush.valid_const", {31'h0, out_valid}, 32'h0);
    flush = 0; stall = 0; instr = mk_instr(5, 0, 0); instr_valid = 1;
    cycle("after_stall");
    chk("after_stall.const", rfa, 32'hCAFE0000);

    // Reset wins over write and stall
    rf_we = 1; rf_waddr = 9; alu_out = 32'h99; cycle("wr_r9");
    rst = 1; stall = 1; rf_waddr = 9; alu_out = 32'h77;
    cycle("rst_mid");
    chk("rst_mid.valid_const", {31'h0, out_valid}, 32'h0);
    rst = 0; stall = 0; rf_we = 0; instr = mk_instr(9, 9, 0); rf_b_sel = 1;
    cycle("rd_r9");
    chk("rd_r9.const", rfa, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(0, 63) == 0);
      instr         = $urandom;
      instr_valid   = 1'($urandom);
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      rf_b_sel      = 1'($urandom);
      immext_sel    = 2'($urandom);
      rf_we         = 1'($urandom);
      rf_waddr      = 5'($urandom);
      rf_wrdata_sel = 1'($urandom);
      alu_out       = $urandom;
      mem_out       = $urandom;
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
